// File: rtl/uart_rx_oversampled.sv
// UART receiver, 8N1, oversampled by the system clock.
// The line is synchronised, a falling edge starts a frame, the start bit is
// re-checked at its centre, and then data and stop bits are sampled one bit
// period apart. A single-entry output buffer with valid/ready handshake holds
// the received byte; framing errors and overruns are reported as one-cycle pulses.
module uart_rx_oversampled #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int clkcount = clk_freq / baud_rate;
  localparam int half     = clkcount / 2;
  localparam int cnt_w    = (clkcount > 1) ? $clog2(clkcount) : 1;

  localparam logic [cnt_w-1:0] half_last = cnt_w'(half - 1);
  localparam logic [cnt_w-1:0] bit_last  = cnt_w'(clkcount - 1);
  localparam logic [cnt_w-1:0] cnt_one   = cnt_w'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_reg;
  logic [cnt_w-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             done_reg;      // stop bit was sampled on the previous edge
  logic             stop_bit_reg;  // value of that stop-bit sample
  logic [2:0]       sync_reg;      // [1] = rx_s, [2] = rx_s_d
  logic             rx_s;
  logic             rx_s_d;

  assign rx_s   = sync_reg[1];
  assign rx_s_d = sync_reg[2];

  // Two-flop synchroniser plus one extra delay stage for falling-edge detection.
  // Reset to idle-high so a line already low after reset reads as a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], rx};
    end
  end

  // Frame FSM, output buffer and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      done_reg     <= 1'b0;
      stop_bit_reg <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      done_reg  <= 1'b0;

      // Consumer handshake empties the buffer; a load below may refill it.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Deliver the frame one edge after its stop bit was sampled.
      if (done_reg) begin
        if (!stop_bit_reg) begin
          frame_err <= 1'b1;
        end else if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (!rx_s && rx_s_d) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (cnt_reg == half_last) begin
            cnt_reg <= '0;
            if (!rx_s) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + cnt_one;
          end
        end
        DATA: begin
          if (cnt_reg == bit_last) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + cnt_one;
          end
        end
        STOP: begin
          if (cnt_reg == bit_last) begin
            cnt_reg      <= '0;
            done_reg     <= 1'b1;
            stop_bit_reg <= rx_s;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + cnt_one;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
